// File: rtl/ahb_pkg.sv
// ahb_pkg: shared bridge types and constants; LOCKED state exists only with ARB_LOCK_EN
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam int DEFAULT_MAX_TENURE = 16;
  typedef enum logic [1:0] {
    PARK,
    OWNED
`ifdef ARB_LOCK_EN
    , LOCKED
`endif
  } arb_state_e;
endpackage

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: request/grant bundle between the AHB masters and the arbiter
interface ahb_arbiter_if #(
  parameter int NUM_MST = 4
);
  logic [NUM_MST-1:0] Hbusreq;
  logic [NUM_MST-1:0] Hlock;
  logic [2*NUM_MST-1:0] Htrans_all;
  logic Hreadyin;
  logic [NUM_MST-1:0] Hgrant;
  logic [$clog2(NUM_MST)-1:0] Hmaster;
  logic [$clog2(NUM_MST)-1:0] Hmaster_d;
  logic Hmastlock;
  modport slave (
    input  Hbusreq, Hlock, Htrans_all, Hreadyin,
    output Hgrant, Hmaster, Hmaster_d, Hmastlock
  );
  modport master (
    output Hbusreq, Hlock, Htrans_all, Hreadyin,
    input  Hgrant, Hmaster, Hmaster_d, Hmastlock
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: first asserted request after ptr, wrapping modulo NUM_MST
module rr_picker #(
  parameter int NUM_MST = 4
) (
  input  logic [NUM_MST-1:0]         req,
  input  logic [$clog2(NUM_MST)-1:0] ptr,
  output logic [$clog2(NUM_MST)-1:0] win,
  output logic                       found
);
  logic [$clog2(NUM_MST)-1:0] idx;
  // Scan from the farthest candidate back so the nearest one after ptr is written last.
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_MST; k >= 1; k--) begin
      idx = $clog2(NUM_MST)'((int'(ptr) + k) % NUM_MST);
      if (req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter with tenure limit; locked transfers enabled by ARB_LOCK_EN
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MST    = 4,
  parameter int MAX_TENURE = DEFAULT_MAX_TENURE
) (
  input logic          Hclk,
  input logic          Hresetn,
  ahb_arbiter_if.slave bus
);
  localparam int MW = $clog2(NUM_MST);
  localparam int TW = $clog2(MAX_TENURE + 1);
  arb_state_e state_q, state_d;
  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [MW-1:0] own_q, own_d, ptr_q, ptr_d, mst_q, mst_d, dmst_q, dmst_d, win;
  logic [TW-1:0] ten_q, ten_d;
  logic lock_q, lock_d, found, beat, other, norm, rearb;
  logic [1:0] own_tr;
  rr_picker #(.NUM_MST(NUM_MST)) u_rr (
    .req  (bus.Hbusreq),
    .ptr  (ptr_q),
    .win  (win),
    .found(found)
  );
  assign own_tr = bus.Htrans_all[{own_q, 1'b0} +: 2];
  assign beat   = (own_tr == HTRANS_NONSEQ) || (own_tr == HTRANS_SEQ);
  assign other  = |(bus.Hbusreq & ~grant_q);
  assign norm   = (state_q == PARK) || !bus.Hbusreq[own_q] || (own_tr == HTRANS_IDLE) ||
                  ((ten_q == TW'(MAX_TENURE - 1)) && other);
`ifdef ARB_LOCK_EN
  assign rearb = (state_q == LOCKED) ? (!bus.Hlock[own_q] && (own_tr == HTRANS_IDLE)) : norm;
`else
  logic unused_hlock;
  assign unused_hlock = ^bus.Hlock;
  assign rearb = norm;
`endif
  // Everything holds while the slave stalls; a ready cycle advances the phases and may re-arbitrate.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d = own_q;
    ptr_d = ptr_q;
    ten_d = ten_q;
    mst_d = mst_q;
    dmst_d = dmst_q;
    lock_d = lock_q;
    if (bus.Hreadyin) begin
      mst_d = own_q;
      dmst_d = mst_q;
`ifdef ARB_LOCK_EN
      lock_d = (state_q == LOCKED);
`endif
      if (beat) ten_d = (ten_q == TW'(MAX_TENURE - 1)) ? '0 : ten_q + 1'b1;
      if (rearb) begin
        own_d = found ? win : '0;
        ptr_d = found ? win : ptr_q;
        grant_d = found ? NUM_MST'(1) << win : NUM_MST'(1);
        state_d = found ? OWNED : PARK;
`ifdef ARB_LOCK_EN
        if (found && bus.Hlock[win]) state_d = LOCKED;
`endif
      end
      if (own_d != own_q) ten_d = '0;
    end
  end
  // State registers; reset parks the bus on master 0 with the pointer on the last master.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= PARK;
      grant_q <= NUM_MST'(1);
      own_q <= '0;
      ptr_q <= MW'(NUM_MST - 1);
      ten_q <= '0;
      mst_q <= '0;
      dmst_q <= '0;
      lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q <= own_d;
      ptr_q <= ptr_d;
      ten_q <= ten_d;
      mst_q <= mst_d;
      dmst_q <= dmst_d;
      lock_q <= lock_d;
    end
  end
  assign bus.Hgrant = grant_q;
  assign bus.Hmaster = mst_q;
  assign bus.Hmaster_d = dmst_q;
  assign bus.Hmastlock = lock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: scoreboard bench for ahb_arbiter; lock scenario runs when ARB_LOCK_EN is defined
module tb_ahb_arbiter;
  localparam int N = 4;
  localparam int MAXT = 16;
  logic Hclk = 1'b0;
  logic Hresetn = 1'b1;
  ahb_arbiter_if #(.NUM_MST(N)) bus ();
  ahb_arbiter #(.NUM_MST(N), .MAX_TENURE(MAXT)) dut (
    .Hclk   (Hclk),
    .Hresetn(Hresetn),
    .bus    (bus)
  );
  always #5 Hclk = ~Hclk;
  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       l;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_state, m_own, m_ptr, m_ten, m_mst, m_dmst, m_lock;
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0;
    m_own = 0;
    m_ptr = N - 1;
    m_ten = 0;
    m_mst = 0;
    m_dmst = 0;
    m_lock = 0;
    exp_q.delete();
  endtask
  task automatic model_step(input logic [3:0] req, input logic [7:0] tr, input logic rdy);
    logic [1:0] ot;
    bit re;
    int w;
    if (!rdy) return;
    ot = tr[2*m_own +: 2];
    re = (m_state == 0) || !req[m_own] || (ot == 2'b00) ||
         (m_ten == MAXT - 1 && (req & ~(4'b0001 << m_own)) != 4'b0);
`ifdef ARB_LOCK_EN
    if (m_state == 2) re = !bus.Hlock[m_own] && (ot == 2'b00);
`endif
    m_dmst = m_mst;
    m_mst = m_own;
    m_lock = (m_state == 2) ? 1 : 0;
    if (ot[1]) m_ten = (m_ten + 1 == MAXT) ? 0 : m_ten + 1;
    if (re) begin
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        if (w != m_own) m_ten = 0;
        m_own = w;
        m_ptr = w;
        m_state = 1;
`ifdef ARB_LOCK_EN
        if (bus.Hlock[w]) m_state = 2;
`endif
      end else begin
        if (m_own != 0) m_ten = 0;
        m_own = 0;
        m_state = 0;
      end
    end
  endtask
  task automatic cycle(input logic [3:0] req, input logic [7:0] tr, input logic rdy = 1'b1,
                       input logic [3:0] lk = 4'b0000);
    exp_t e;
    bus.Hbusreq = req;
    bus.Htrans_all = tr;
    bus.Hreadyin = rdy;
    bus.Hlock = lk;
    model_step(req, tr, rdy);
    exp_q.push_back('{g: 4'(1 << m_own), m: 2'(m_mst), md: 2'(m_dmst), l: m_lock[0]});
    @(posedge Hclk);
    #1;
    e = exp_q.pop_front();
    check("Hgrant", 8'(bus.Hgrant), 8'(e.g));
    check("Hmaster", 8'(bus.Hmaster), 8'(e.m));
    check("Hmaster_d", 8'(bus.Hmaster_d), 8'(e.md));
    check("Hmastlock", 8'(bus.Hmastlock), 8'(e.l));
  endtask
  task automatic apply_reset();
    Hresetn = 1'b0;
    model_reset();
    #1;
    check("rst_grant", 8'(bus.Hgrant), 8'h01);
    check("rst_master", 8'(bus.Hmaster), 8'h00);
    check("rst_master_d", 8'(bus.Hmaster_d), 8'h00);
    check("rst_mastlock", 8'(bus.Hmastlock), 8'h00);
    @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;
  endtask
  initial begin
    bus.Hbusreq = '0;
    bus.Hlock = '0;
    bus.Htrans_all = '0;
    bus.Hreadyin = 1'b1;
    #2;
    apply_reset();
    repeat (5) cycle(4'b0000, 8'h00);
    check("park_grant", 8'(bus.Hgrant), 8'h01);
    cycle(4'b1010, 8'h08);
    check("rr_first", 8'(bus.Hgrant), 8'h02);
    repeat (3) cycle(4'b1010, 8'h0C);
    cycle(4'b1000, 8'h00);
    check("handover", 8'(bus.Hgrant), 8'h08);
    cycle(4'b1000, 8'h80);
    check("lag_master", 8'(bus.Hmaster), 8'h03);
    check("lag_master_d", 8'(bus.Hmaster_d), 8'h01);
    repeat (4) cycle(4'b0001, 8'h00, 1'b0);
    check("stall_grant", 8'(bus.Hgrant), 8'h08);
    check("stall_master", 8'(bus.Hmaster), 8'h03);
    cycle(4'b0001, 8'h02);
    check("stall_release", 8'(bus.Hgrant), 8'h01);
    repeat (2) cycle(4'b0001, 8'h03);
    cycle(4'b0100, 8'h00);
    check("drop_raise", 8'(bus.Hgrant), 8'h04);
    cycle(4'b0100, 8'h00);
    check("sole_rewin", 8'(bus.Hgrant), 8'h04);
    apply_reset();
    cycle(4'b0011, 8'h02);
    repeat (14) cycle(4'b0011, 8'h03);
    check("tenure_hold", 8'(bus.Hgrant), 8'h01);
    cycle(4'b0011, 8'h03);
    check("tenure_move", 8'(bus.Hgrant), 8'h02);
    cycle(4'b0010, 8'h0D);
    repeat (20) cycle(4'b0010, 8'h04);
    check("busy_hold", 8'(bus.Hgrant), 8'h02);
    repeat (20) cycle(4'b0010, 8'h0C);
    check("tenure_keep", 8'(bus.Hgrant), 8'h02);
    apply_reset();
    cycle(4'b0100, 8'h20);
    check("post_reset", 8'(bus.Hgrant), 8'h04);
`ifdef ARB_LOCK_EN
    apply_reset();
    cycle(4'b0100, 8'h20, 1'b1, 4'b0100);
    repeat (40) cycle(4'b1111, 8'hFF, 1'b1, 4'b0100);
    check("lock_grant", 8'(bus.Hgrant), 8'h04);
    check("lock_mastlock", 8'(bus.Hmastlock), 8'h01);
    cycle(4'b1111, 8'hFF, 1'b1, 4'b0000);
    check("lock_busy_hold", 8'(bus.Hgrant), 8'h04);
    cycle(4'b1111, 8'hCF, 1'b1, 4'b0000);
    check("lock_release", 8'(bus.Hgrant), 8'h08);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
